vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 15 +
 rtl/vram_arbiter_if.sv | 41 ++++
 rtl/vram_wbuf_fifo.sv | 53 +++++
 rtl/vram_arbiter.sv | 136 +++++++++++++
 tb/tb_vram_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// Shared constants and grant encoding for the VRAM arbiter and its write posting buffer.
package vram_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 12;
    localparam int WBUF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_VGA = 2'd1,
        GNT_WR  = 2'd2,
        GNT_RD  = 2'd3
    } gnt_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the scan-out, game-logic write/read and VRAM port signals around the arbiter.
interface vram_arbiter_if #(
    parameter int ADDR_W = vram_pkg::ADDR_W_DEF,
    parameter int DATA_W = vram_pkg::DATA_W_DEF
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // The arbiter side; requesters and the VRAM model sit on the master side.
    modport slave (
        input  vga_req, vga_addr, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
        output vga_data, vga_valid, wr_ack, rd_ack, rd_data, rd_valid,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output vga_req, vga_addr, wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rdata,
        input  vga_data, vga_valid, wr_ack, rd_ack, rd_data, rd_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/vram_wbuf_fifo.sv
// Small write posting FIFO holding {addr, data} pairs; caller never pushes when full
// (unless popping in the same cycle) and never pops when empty.
module vram_wbuf_fifo
    import vram_pkg::*;
#(
    parameter int WIDTH = ADDR_W_DEF + DATA_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);

    logic [WIDTH-1:0] mem_q [WBUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(WBUF_DEPTH));

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out reads win outright, game writes/reads share round-robin.
// Define VRAM_ARBITER_WBUF_EN to post game writes through a 4-entry FIFO.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic        clk,
    input  logic        clr,
    vram_arbiter_if.slave bus
);

    gnt_e              state_q, state_d;
    logic              rr_q, rr_d;
    logic [DATA_W-1:0] vga_data_q;
    logic [DATA_W-1:0] rd_data_q;

    logic              wsrc_req;
    logic [ADDR_W-1:0] wsrc_addr;
    logic [DATA_W-1:0] wsrc_data;
    logic              rsrc_req;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

`ifdef VRAM_ARBITER_WBUF_EN
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic [ADDR_W+DATA_W-1:0] fifo_head;

    // A full FIFO may still accept when its head drains this same cycle.
    assign fifo_pop  = (state_d == GNT_WR);
    assign fifo_push = clr && bus.wr_req && (!fifo_full || fifo_pop);

    assign wsrc_req               = !fifo_empty;
    assign {wsrc_addr, wsrc_data} = fifo_head;
    assign rsrc_req               = bus.rd_req && fifo_empty && !bus.wr_req;
    assign bus.wr_ack             = fifo_push;

    vram_wbuf_fifo #(
        .WIDTH (ADDR_W + DATA_W)
    ) u_wbuf (
        .clk         (clk),
        .clr         (clr),
        .push_i      (fifo_push),
        .push_data_i ({bus.wr_addr, bus.wr_data}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );
`else
    assign wsrc_req   = bus.wr_req;
    assign wsrc_addr  = bus.wr_addr;
    assign wsrc_data  = bus.wr_data;
    assign rsrc_req   = bus.rd_req;
    assign bus.wr_ack = clr && (state_d == GNT_WR);
`endif

    // rr_q low means the write side wins the next contested cycle.
    always_comb begin
        state_d = IDLE;
        rr_d    = rr_q;
        if (bus.vga_req) begin
            state_d = GNT_VGA;
        end else if (wsrc_req && (!rsrc_req || !rr_q)) begin
            state_d = GNT_WR;
            rr_d    = 1'b1;
        end else if (rsrc_req) begin
            state_d = GNT_RD;
            rr_d    = 1'b0;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (clr) begin
            case (state_d)
                GNT_VGA: begin
                    mem_en   = 1'b1;
                    mem_addr = bus.vga_addr;
                end
                GNT_WR: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wsrc_addr;
                    mem_wdata = wsrc_data;
                end
                GNT_RD: begin
                    mem_en   = 1'b1;
                    mem_addr = bus.rd_addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            vga_data_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (state_q == GNT_VGA) begin
                vga_data_q <= bus.mem_rdata;
            end
            if (state_q == GNT_RD) begin
                rd_data_q <= bus.mem_rdata;
            end
        end
    end

    // The VRAM returns data during the cycle after the grant; pass it through then hold it.
    assign bus.vga_valid = (state_q == GNT_VGA);
    assign bus.rd_valid  = (state_q == GNT_RD);
    assign bus.vga_data  = bus.vga_valid ? bus.mem_rdata : vga_data_q;
    assign bus.rd_data   = bus.rd_valid  ? bus.mem_rdata : rd_data_q;

    assign bus.rd_ack    = clr && (state_d == GNT_RD);
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency VRAM model.
module tb_vram_arbiter;

    logic clk;
    logic clr;
    int   checkCount;
    int   errorCount;

    vram_arbiter_if #(.ADDR_W(16), .DATA_W(12)) bus ();

    vram_arbiter #(.ADDR_W(16), .DATA_W(12)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations read back a fixed address-derived pattern.
    function automatic logic [11:0] patternOf(input logic [15:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    logic [11:0] vram    [0:65535];
    bit          written [0:65535];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                vram[bus.mem_addr]    <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= written[bus.mem_addr] ? vram[bus.mem_addr] : patternOf(bus.mem_addr);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic vga, input logic [15:0] vaddr,
                                 input logic wr, input logic [15:0] waddr, input logic [11:0] wdata,
                                 input logic rd, input logic [15:0] raddr);
        bus.vga_req  = vga;
        bus.vga_addr = vaddr;
        bus.wr_req   = wr;
        bus.wr_addr  = waddr;
        bus.wr_data  = wdata;
        bus.rd_req   = rd;
        bus.rd_addr  = raddr;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        clr        = 1'b0;
        applyStimulus(1'b1, 16'h0001, 1'b1, 16'h0005, 12'h123, 1'b1, 16'h0006);

        @(negedge clk);
        checkOutput("rst_mem_en",    32'(bus.mem_en),    32'h0);
        checkOutput("rst_mem_we",    32'(bus.mem_we),    32'h0);
        checkOutput("rst_wr_ack",    32'(bus.wr_ack),    32'h0);
        checkOutput("rst_rd_ack",    32'(bus.rd_ack),    32'h0);
        checkOutput("rst_vga_valid", 32'(bus.vga_valid), 32'h0);
        checkOutput("rst_rd_valid",  32'(bus.rd_valid),  32'h0);
        checkOutput("rst_vga_data",  32'(bus.vga_data),  32'h0);
        checkOutput("rst_rd_data",   32'(bus.rd_data),   32'h0);

        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b0, 16'h0);
        clr = 1'b1;
        @(negedge clk);
        checkOutput("idle_mem_en", 32'(bus.mem_en), 32'h0);

`ifndef VRAM_ARBITER_WBUF_EN
        // Continuous scan-out starves both game requesters.
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            applyStimulus(1'b1, 16'(16'h0100 + c), 1'b1, 16'h0200, 12'h0AA, 1'b1, 16'h0300);
            @(negedge clk);
            checkOutput("vga_wr_ack",   32'(bus.wr_ack),    32'h0);
            checkOutput("vga_rd_ack",   32'(bus.rd_ack),    32'h0);
            checkOutput("vga_mem_we",   32'(bus.mem_we),    32'h0);
            checkOutput("vga_mem_addr", 32'(bus.mem_addr),  32'(16'h0100 + c));
            checkOutput("vga_valid",    32'(bus.vga_valid), (c > 0) ? 32'h1 : 32'h0);
            if (c > 0) begin
                checkOutput("vga_data", 32'(bus.vga_data), 32'(patternOf(16'(16'h0100 + c - 1))));
            end
        end
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("vga_tail_valid", 32'(bus.vga_valid), 32'h1);
        checkOutput("vga_tail_data",  32'(bus.vga_data),  32'(patternOf(16'h0104)));
        checkOutput("vga_tail_en",    32'(bus.mem_en),    32'h0);
        nextCycle();
        @(negedge clk);
        checkOutput("vga_hold_valid", 32'(bus.vga_valid), 32'h0);
        checkOutput("vga_hold_data",  32'(bus.vga_data),  32'(patternOf(16'h0104)));

        // Write then read of the same address.
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h0010, 12'hF00, 1'b1, 16'h0010);
        @(negedge clk);
        checkOutput("raw_wr_ack",    32'(bus.wr_ack),    32'h1);
        checkOutput("raw_rd_ack0",   32'(bus.rd_ack),    32'h0);
        checkOutput("raw_mem_we",    32'(bus.mem_we),    32'h1);
        checkOutput("raw_mem_addr",  32'(bus.mem_addr),  32'h0010);
        checkOutput("raw_mem_wdata", 32'(bus.mem_wdata), 32'hF00);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b1, 16'h0010);
        @(negedge clk);
        checkOutput("raw_rd_ack",    32'(bus.rd_ack),   32'h1);
        checkOutput("raw_wr_ack0",   32'(bus.wr_ack),   32'h0);
        checkOutput("raw_rd_we",     32'(bus.mem_we),   32'h0);
        checkOutput("raw_rd_addr",   32'(bus.mem_addr), 32'h0010);
        checkOutput("raw_rd_valid0", 32'(bus.rd_valid), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("raw_rd_valid",  32'(bus.rd_valid),  32'h1);
        checkOutput("raw_rd_data",   32'(bus.rd_data),   32'hF00);
        checkOutput("raw_vga_valid", 32'(bus.vga_valid), 32'h0);

        // Contested write/read alternate starting with the write.
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            applyStimulus(1'b0, 16'h0, 1'b1, 16'h0020, 12'hABC, 1'b1, 16'h0030);
            @(negedge clk);
            checkOutput("rr_wr_ack",   32'(bus.wr_ack),   (k % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput("rr_rd_ack",   32'(bus.rd_ack),   (k % 2 == 1) ? 32'h1 : 32'h0);
            checkOutput("rr_mem_we",   32'(bus.mem_we),   (k % 2 == 0) ? 32'h1 : 32'h0);
            checkOutput("rr_rd_valid", 32'(bus.rd_valid), (k > 0 && k % 2 == 0) ? 32'h1 : 32'h0);
        end
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("rr_tail_valid", 32'(bus.rd_valid), 32'h1);
        checkOutput("rr_tail_data",  32'(bus.rd_data),  32'(patternOf(16'h0030)));

        // Reset the cycle after a read grant: the return must be dropped.
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b1, 16'h0040);
        @(negedge clk);
        checkOutput("rst_rd_grant", 32'(bus.rd_ack), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h0044, 12'h777, 1'b0, 16'h0);
        clr = 1'b0;
        @(negedge clk);
        checkOutput("mid_rd_valid", 32'(bus.rd_valid), 32'h0);
        checkOutput("mid_rd_data",  32'(bus.rd_data),  32'h0);
        checkOutput("mid_vga_data", 32'(bus.vga_data), 32'h0);
        checkOutput("mid_mem_en",   32'(bus.mem_en),   32'h0);
        checkOutput("mid_mem_we",   32'(bus.mem_we),   32'h0);
        checkOutput("mid_wr_ack",   32'(bus.wr_ack),   32'h0);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b0, 16'h0);
        clr = 1'b1;
        @(negedge clk);
        checkOutput("post_rd_valid", 32'(bus.rd_valid), 32'h0);
        checkOutput("post_mem_en",   32'(bus.mem_en),   32'h0);

        // Leave the pointer favouring read, then check reset returns it to write.
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h0044, 12'h777, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("resume_wr_ack", 32'(bus.wr_ack), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b0, 16'h0);
        clr = 1'b0;
        @(negedge clk);
        checkOutput("pulse_mem_en", 32'(bus.mem_en), 32'h0);
        nextCycle();
        clr = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h0050, 12'h123, 1'b1, 16'h0044);
        @(negedge clk);
        checkOutput("ptr_rst_wr_ack", 32'(bus.wr_ack), 32'h1);
        checkOutput("ptr_rst_rd_ack", 32'(bus.rd_ack), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b1, 16'h0044);
        @(negedge clk);
        checkOutput("ptr_rd_ack", 32'(bus.rd_ack), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("keep_rd_valid", 32'(bus.rd_valid), 32'h1);
        checkOutput("keep_rd_data",  32'(bus.rd_data),  32'h777);
`else
        // Posted writes fill the FIFO while scan-out owns the VRAM.
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(1'b1, 16'h0100, 1'b1, 16'(16'h0050 + i), 12'(16'h111 * (i + 1)), 1'b1, 16'h0052);
            @(negedge clk);
            checkOutput("wb_wr_ack", 32'(bus.wr_ack), (i < 4) ? 32'h1 : 32'h0);
            checkOutput("wb_rd_ack", 32'(bus.rd_ack), 32'h0);
            checkOutput("wb_mem_we", 32'(bus.mem_we), 32'h0);
        end
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b1, 16'h0054, 12'h555, 1'b1, 16'h0052);
        @(negedge clk);
        checkOutput("wb_fifth_ack", 32'(bus.wr_ack),    32'h1);
        checkOutput("wb_drain_we",  32'(bus.mem_we),    32'h1);
        checkOutput("wb_drain_adr", 32'(bus.mem_addr),  32'h0050);
        checkOutput("wb_drain_dat", 32'(bus.mem_wdata), 32'h111);
        checkOutput("wb_rd_block",  32'(bus.rd_ack),    32'h0);
        for (int j = 1; j < 5; j++) begin
            nextCycle();
            applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b1, 16'h0052);
            @(negedge clk);
            checkOutput("wb_drain_we",  32'(bus.mem_we),   32'h1);
            checkOutput("wb_drain_adr", 32'(bus.mem_addr), 32'(16'h0050 + j));
            checkOutput("wb_rd_block",  32'(bus.rd_ack),   32'h0);
        end
        nextCycle();
        @(negedge clk);
        checkOutput("wb_rd_ack",  32'(bus.rd_ack),   32'h1);
        checkOutput("wb_rd_addr", 32'(bus.mem_addr), 32'h0052);
        nextCycle();
        applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 12'h0, 1'b0, 16'h0);
        @(negedge clk);
        checkOutput("wb_rd_valid", 32'(bus.rd_valid), 32'h1);
        checkOutput("wb_rd_data",  32'(bus.rd_data),  32'h333);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
